// File: rtl/w0rm_arb_pkg.sv
// w0rm_arb_pkg
//   Shared types and helpers for the W0RM memory arbiter.
//   - arb_port_e    : identifies the requester that owns the RAM in a cycle
//   - ARB_*         : default widths used by the arbiter and its slots
//   - arb_hw_select : picks the little-endian halfword of a RAM word
package w0rm_arb_pkg;

    typedef enum logic {
        ARB_PORT_DATA = 1'b0,
        ARB_PORT_INST = 1'b1
    } arb_port_e;

    localparam int ARB_DATA_WIDTH     = 32;
    localparam int ARB_INST_WIDTH     = 16;
    localparam int ARB_RAM_ADDR_WIDTH = 10;

    // hi=0 selects bits [15:0], hi=1 selects bits [31:16].
    function automatic logic [ARB_INST_WIDTH-1:0] arb_hw_select(
        input logic [ARB_DATA_WIDTH-1:0] word,
        input logic                      hi
    );
        if (hi) begin
            return word[2*ARB_INST_WIDTH-1:ARB_INST_WIDTH];
        end
        return word[ARB_INST_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/w0rm_arb_req_slot.sv
// w0rm_arb_req_slot
//   Single-entry request holding register for one arbiter port.
//   A request is loaded when req_valid && ready && req_keep and stays pending
//   until the cycle it is granted. ready is high when the slot is empty or is
//   being drained this cycle, so a new request can refill it back to back.
// Ports
//   clk, rst            clock, asynchronous active-high reset (control only)
//   req_valid           requester presents a request
//   req_keep            0 = accept the handshake but drop the request
//   req_addr/wdata/we   request payload
//   gnt                 slot owns the RAM this cycle
//   ready               slot can accept this cycle
//   pend                slot holds a request
//   addr_q/wdata_q/we_q held payload
module w0rm_arb_req_slot
    import w0rm_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_RAM_ADDR_WIDTH,
    parameter int DATA_W = ARB_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_keep,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_we,
    input  logic              gnt,
    output logic              ready,
    output logic              pend,
    output logic [ADDR_W-1:0] addr_q,
    output logic [DATA_W-1:0] wdata_q,
    output logic              we_q
);

    logic load;

    // ready depends only on slot state and grant, never on req_valid.
    assign ready = !pend | gnt;
    assign load  = req_valid & ready & req_keep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (load) begin
            pend <= 1'b1;
        end else if (gnt) begin
            pend <= 1'b0;
        end
    end

    // Payload is only meaningful while pend is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
        end
    end

endmodule

// File: rtl/w0rm_mem_arbiter.sv
// w0rm_mem_arbiter
//   Shares one synchronous single-port RAM between the W0RM data port and the
//   instruction-fetch port. Each port owns a single-entry request slot; the
//   grant is combinational from the pending slots and the RAM response is
//   returned one cycle after the grant with a valid pulse.
// Ports
//   core_clk, reset                clock, asynchronous active-high reset
//   d_addr_i/d_data_i/d_read_i/
//   d_write_i/d_valid_i/d_ready_o  data request handshake
//   d_data_o/d_valid_o             data read result / write ack
//   i_addr_i/i_valid_i/i_ready_o   fetch request handshake
//   i_data_o/i_valid_o             fetched halfword
//   ram_en_o/ram_we_o/ram_addr_o/
//   ram_din_o/ram_dout_i           RAM interface (read data one cycle after en)
// Build option
//   W0RM_ARB_ROUND_ROBIN_EN : on a tie the port not granted last time wins.
//   Undefined               : the data port always wins a tie.
module w0rm_mem_arbiter
    import w0rm_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = ARB_DATA_WIDTH,
    parameter int ADDR_WIDTH     = 32,
    parameter int INST_WIDTH     = ARB_INST_WIDTH,
    parameter int RAM_ADDR_WIDTH = ARB_RAM_ADDR_WIDTH
) (
    input  logic                      core_clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     d_addr_i,
    input  logic [DATA_WIDTH-1:0]     d_data_i,
    input  logic                      d_read_i,
    input  logic                      d_write_i,
    input  logic                      d_valid_i,
    output logic                      d_ready_o,
    output logic [DATA_WIDTH-1:0]     d_data_o,
    output logic                      d_valid_o,
    input  logic [ADDR_WIDTH-1:0]     i_addr_i,
    input  logic                      i_valid_i,
    output logic                      i_ready_o,
    output logic [INST_WIDTH-1:0]     i_data_o,
    output logic                      i_valid_o,
    output logic                      ram_en_o,
    output logic                      ram_we_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_din_o,
    input  logic [DATA_WIDTH-1:0]     ram_dout_i
);

    logic                      d_keep;
    logic                      d_pend_p0;
    logic [RAM_ADDR_WIDTH-1:0] d_addr_p0;
    logic [DATA_WIDTH-1:0]     d_wdata_p0;
    logic                      d_we_p0;
    logic                      i_pend_p0;
    logic [RAM_ADDR_WIDTH:0]   i_addr_p0;   // word address + halfword select in bit 0
    logic [DATA_WIDTH-1:0]     i_wdata_p0;
    logic                      i_we_p0;
    logic                      gnt_any_p0;
    arb_port_e                 gnt_port_p0;
    logic                      gnt_d_p0;
    logic                      gnt_i_p0;
    logic                      d_vld_p1;
    logic                      i_vld_p1;
    logic                      i_hsel_p1;
    logic                      unused_addr_bits;

    // Upper address bits alias and byte-offset bits are not used by the RAM.
    assign unused_addr_bits = ^{d_addr_i, i_addr_i};

    // A data request with neither read nor write completes the handshake
    // but never occupies the slot; read+write together counts as a write.
    assign d_keep = d_read_i | d_write_i;

    // Stage p0: request slots
    w0rm_arb_req_slot #(
        .ADDR_W (RAM_ADDR_WIDTH),
        .DATA_W (DATA_WIDTH)
    ) u_d_slot (
        .clk       (core_clk),
        .rst       (reset),
        .req_valid (d_valid_i),
        .req_keep  (d_keep),
        .req_addr  (d_addr_i[RAM_ADDR_WIDTH+1:2]),
        .req_wdata (d_data_i),
        .req_we    (d_write_i),
        .gnt       (gnt_d_p0),
        .ready     (d_ready_o),
        .pend      (d_pend_p0),
        .addr_q    (d_addr_p0),
        .wdata_q   (d_wdata_p0),
        .we_q      (d_we_p0)
    );

    w0rm_arb_req_slot #(
        .ADDR_W (RAM_ADDR_WIDTH + 1),
        .DATA_W (DATA_WIDTH)
    ) u_i_slot (
        .clk       (core_clk),
        .rst       (reset),
        .req_valid (i_valid_i),
        .req_keep  (1'b1),
        .req_addr  (i_addr_i[RAM_ADDR_WIDTH+1:1]),
        .req_wdata ('0),
        .req_we    (1'b0),
        .gnt       (gnt_i_p0),
        .ready     (i_ready_o),
        .pend      (i_pend_p0),
        .addr_q    (i_addr_p0),
        .wdata_q   (i_wdata_p0),
        .we_q      (i_we_p0)
    );

`ifdef W0RM_ARB_ROUND_ROBIN_EN
    arb_port_e last_gnt;

    // Starts at "inst" so the data port wins the first tie after reset.
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            last_gnt <= ARB_PORT_INST;
        end else if (gnt_any_p0) begin
            last_gnt <= gnt_port_p0;
        end
    end
`endif

    always_comb begin
        gnt_any_p0  = d_pend_p0 | i_pend_p0;
        gnt_port_p0 = ARB_PORT_DATA;
        if (d_pend_p0 && i_pend_p0) begin
`ifdef W0RM_ARB_ROUND_ROBIN_EN
            if (last_gnt == ARB_PORT_DATA) begin
                gnt_port_p0 = ARB_PORT_INST;
            end
`endif
        end else if (i_pend_p0) begin
            gnt_port_p0 = ARB_PORT_INST;
        end
    end

    assign gnt_d_p0 = gnt_any_p0 && (gnt_port_p0 == ARB_PORT_DATA);
    assign gnt_i_p0 = gnt_any_p0 && (gnt_port_p0 == ARB_PORT_INST);

    // RAM command is zero whenever no slot is granted.
    always_comb begin
        ram_en_o   = gnt_any_p0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_din_o  = '0;
        if (gnt_d_p0) begin
            ram_we_o   = d_we_p0;
            ram_addr_o = d_addr_p0;
            ram_din_o  = d_we_p0 ? d_wdata_p0 : '0;
        end else if (gnt_i_p0) begin
            ram_we_o   = i_we_p0;
            ram_addr_o = i_addr_p0[RAM_ADDR_WIDTH:1];
            ram_din_o  = i_we_p0 ? i_wdata_p0 : '0;
        end
    end

    // Stage p1: RAM response
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            d_vld_p1 <= 1'b0;
            i_vld_p1 <= 1'b0;
        end else begin
            d_vld_p1 <= gnt_d_p0;
            i_vld_p1 <= gnt_i_p0;
        end
    end

    always_ff @(posedge core_clk) begin
        if (gnt_i_p0) begin
            i_hsel_p1 <= i_addr_p0[0];
        end
    end

    // Read data is gated so the result buses stay at zero between responses.
    assign d_valid_o = d_vld_p1;
    assign i_valid_o = i_vld_p1;
    assign d_data_o  = d_vld_p1 ? ram_dout_i : '0;
    assign i_data_o  = i_vld_p1 ? arb_hw_select(ram_dout_i, i_hsel_p1) : '0;

endmodule

// File: tb/tb_w0rm_mem_arbiter.sv
// tb_w0rm_mem_arbiter
//   Scoreboard bench for w0rm_mem_arbiter with a behavioural single-port RAM.
//   Expected responses are queued when a request is accepted and compared
//   when the arbiter raises the matching valid.
module tb_w0rm_mem_arbiter;

`ifdef W0RM_ARB_ROUND_ROBIN_EN
    localparam int T4_ILAT  = 3;
    localparam int T4_IRESP = 1;
`else
    localparam int T4_ILAT  = 0;
    localparam int T4_IRESP = 0;
`endif

    logic        core_clk = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_data_i = '0;
    logic        d_read_i = 1'b0;
    logic        d_write_i = 1'b0;
    logic        d_valid_i = 1'b0;
    logic        d_ready_o;
    logic [31:0] d_data_o;
    logic        d_valid_o;
    logic [31:0] i_addr_i = '0;
    logic        i_valid_i = 1'b0;
    logic        i_ready_o;
    logic [15:0] i_data_o;
    logic        i_valid_o;
    logic        ram_en_o;
    logic        ram_we_o;
    logic [9:0]  ram_addr_o;
    logic [31:0] ram_din_o;
    logic [31:0] ram_dout = '0;

    typedef struct {
        logic [31:0] data;
        bit          wr;
        int          exp_cyc;
    } sb_t;

    sb_t dq[$];
    sb_t iq[$];
    sb_t md;
    sb_t mi;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int d_resp_cnt = 0;
    int i_resp_cnt = 0;
    int n0;
    int n1;
    int cnt;

    // RAM stores value ^ pat(addr), so the zero-initialised array reads back
    // as a known non-zero pattern without a second writer.
    logic [31:0] mem [0:1023] = '{default: '0};
    logic [31:0] ref_mem [0:1023];

    function automatic logic [31:0] pat(input logic [9:0] a);
        return {16'h5A5A, 6'd0, a};
    endfunction

    w0rm_mem_arbiter dut (
        .core_clk   (core_clk),
        .reset      (reset),
        .d_addr_i   (d_addr_i),
        .d_data_i   (d_data_i),
        .d_read_i   (d_read_i),
        .d_write_i  (d_write_i),
        .d_valid_i  (d_valid_i),
        .d_ready_o  (d_ready_o),
        .d_data_o   (d_data_o),
        .d_valid_o  (d_valid_o),
        .i_addr_i   (i_addr_i),
        .i_valid_i  (i_valid_i),
        .i_ready_o  (i_ready_o),
        .i_data_o   (i_data_o),
        .i_valid_o  (i_valid_o),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_din_o  (ram_din_o),
        .ram_dout_i (ram_dout)
    );

    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) cyc <= cyc + 1;

    always @(posedge core_clk) begin
        if (ram_en_o) begin
            if (ram_we_o) mem[ram_addr_o] <= ram_din_o ^ pat(ram_addr_o);
            ram_dout <= mem[ram_addr_o] ^ pat(ram_addr_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic push_d(input logic [31:0] a, input logic [31:0] wd, input bit wr, input int lat);
        sb_t e;
        e.wr = wr;
        e.exp_cyc = (lat > 0) ? cyc + lat : -1;
        if (wr) begin
            ref_mem[a[11:2]] = wd;
            e.data = wd;
        end else begin
            e.data = ref_mem[a[11:2]];
        end
        dq.push_back(e);
    endtask

    task automatic push_i(input logic [31:0] a, input int lat);
        sb_t e;
        logic [31:0] w;
        w = ref_mem[a[11:2]];
        e.wr = 1'b0;
        e.exp_cyc = (lat > 0) ? cyc + lat : -1;
        e.data = a[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
        iq.push_back(e);
    endtask

    // lat < 0: no response expected; lat = 0: value only; lat > 0: cycles from request
    task automatic drive_d(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                           input logic wr, input int lat);
        int n;
        n = 0;
        d_addr_i = a; d_data_i = wd; d_read_i = rd; d_write_i = wr; d_valid_i = 1'b1;
        @(negedge core_clk);
        while (!d_ready_o && n < 100) begin
            n++;
            @(negedge core_clk);
        end
        if (!d_ready_o) check("d_accept_timeout", 32'd0, 32'd1);
        else if (lat >= 0 && (rd || wr)) push_d(a, wd, wr, lat);
        step();
        d_valid_i = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0;
    endtask

    task automatic drive_i(input logic [31:0] a, input int lat);
        int n;
        n = 0;
        i_addr_i = a; i_valid_i = 1'b1;
        @(negedge core_clk);
        while (!i_ready_o && n < 100) begin
            n++;
            @(negedge core_clk);
        end
        if (!i_ready_o) check("i_accept_timeout", 32'd0, 32'd1);
        else if (lat >= 0) push_i(a, lat);
        step();
        i_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && (dq.size() != 0 || iq.size() != 0); k++) @(negedge core_clk);
        check("drain", 32'(dq.size() + iq.size()), 32'd0);
        step();
    endtask

    // Response monitor / scoreboard compare
    always @(negedge core_clk) begin
        if (d_valid_o) begin
            d_resp_cnt++;
            if (dq.size() == 0) begin
                check("d_unexpected_resp", 32'd1, 32'd0);
            end else begin
                md = dq.pop_front();
                if (!md.wr) check("d_data", d_data_o, md.data);
                if (md.exp_cyc >= 0) check("d_latency", 32'(cyc), 32'(md.exp_cyc));
            end
        end
        if (i_valid_o) begin
            i_resp_cnt++;
            if (iq.size() == 0) begin
                check("i_unexpected_resp", 32'd1, 32'd0);
            end else begin
                mi = iq.pop_front();
                check("i_data", 32'(i_data_o), mi.data);
                if (mi.exp_cyc >= 0) check("i_latency", 32'(cyc), 32'(mi.exp_cyc));
            end
        end
    end

    initial begin
        logic [31:0] a;
        for (int k = 0; k < 1024; k++) ref_mem[k] = pat(10'(k));

        // Reset state
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        check("rst_d_ready", 32'(d_ready_o), 32'd1);
        check("rst_i_ready", 32'(i_ready_o), 32'd1);
        check("rst_d_valid", 32'(d_valid_o), 32'd0);
        check("rst_i_valid", 32'(i_valid_o), 32'd0);
        check("rst_ram_en", 32'(ram_en_o), 32'd0);
        check("rst_ram_we", 32'(ram_we_o), 32'd0);
        check("rst_ram_addr", 32'(ram_addr_o), 32'd0);
        check("rst_ram_din", ram_din_o, 32'd0);
        check("rst_d_data", d_data_o, 32'd0);
        check("rst_i_data", 32'(i_data_o), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Write then read word 4
        drive_d(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 2);
        @(negedge core_clk);
        check("t1_wr_en", 32'(ram_en_o), 32'd1);
        check("t1_wr_we", 32'(ram_we_o), 32'd1);
        check("t1_wr_addr", 32'(ram_addr_o), 32'd4);
        check("t1_wr_din", ram_din_o, 32'hDEADBEEF);
        step();
        drive_d(32'h10, 32'h0, 1'b1, 1'b0, 2);
        @(negedge core_clk);
        check("t1_rd_we", 32'(ram_we_o), 32'd0);
        check("t1_rd_addr", 32'(ram_addr_o), 32'd4);
        step();
        wait_idle();

        // Neither read nor write: handshake only, no response
        n0 = d_resp_cnt;
        drive_d(32'h80, 32'h0, 1'b0, 1'b0, -1);
        @(negedge core_clk);
        check("discard_no_ram_en", 32'(ram_en_o), 32'd0);
        repeat (4) step();
        check("discard_no_resp", 32'(d_resp_cnt - n0), 32'd0);

        // Read and write together behaves as a write
        drive_d(32'h20, 32'h0BADF00D, 1'b1, 1'b1, 2);
        @(negedge core_clk);
        check("both_is_write", 32'(ram_we_o), 32'd1);
        step();
        drive_d(32'h20, 32'h0, 1'b1, 1'b0, 2);
        wait_idle();

        // Fetch both halfwords of word 4
        drive_d(32'h10, 32'h1234ABCD, 1'b0, 1'b1, 2);
        wait_idle();
        drive_i(32'h10, 2);
        drive_i(32'h12, 2);
        wait_idle();

        // Same-cycle data read and fetch
        fork
            drive_d(32'h20, 32'h0, 1'b1, 1'b0, 2);
            drive_i(32'h12, 3);
        join
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge core_clk);
            if (!i_ready_o) cnt++;
        end
        check("t3_i_ready_low_cycles", 32'(cnt), 32'd1);
        step();
        wait_idle();

        // Continuous data reads against one pending fetch
        n0 = i_resp_cnt;
        fork
            drive_i(32'h14, T4_ILAT);
            begin
                a = 32'h100;
                d_read_i = 1'b1; d_write_i = 1'b0; d_valid_i = 1'b1;
                for (int k = 0; k < 16; k++) begin
                    d_addr_i = a;
                    @(negedge core_clk);
                    if (d_ready_o) begin
                        push_d(a, 32'h0, 1'b0, 0);
                        a = a + 32'd4;
                    end
                    step();
                end
                d_valid_i = 1'b0; d_read_i = 1'b0;
            end
        join
        check("t4_fetch_during_stream", 32'(i_resp_cnt - n0), 32'(T4_IRESP));
        wait_idle();

        // Address aliasing above the RAM width
        drive_d(32'h1010, 32'h0, 1'b1, 1'b0, 2);
        @(negedge core_clk);
        check("t6_alias_addr", 32'(ram_addr_o), 32'd4);
        step();
        wait_idle();

        // Reset with both slots pending drops everything
        fork
            drive_d(32'h40, 32'hCAFEF00D, 1'b0, 1'b1, -1);
            drive_i(32'h40, -1);
        join
        n0 = d_resp_cnt;
        n1 = i_resp_cnt;
        reset = 1'b1;
        @(negedge core_clk);
        check("t5_d_ready", 32'(d_ready_o), 32'd1);
        check("t5_i_ready", 32'(i_ready_o), 32'd1);
        check("t5_ram_en", 32'(ram_en_o), 32'd0);
        step();
        step();
        reset = 1'b0;
        repeat (6) step();
        check("t5_no_d_resp", 32'(d_resp_cnt - n0), 32'd0);
        check("t5_no_i_resp", 32'(i_resp_cnt - n1), 32'd0);
        check("t5_d_ready_after", 32'(d_ready_o), 32'd1);
        drive_d(32'h40, 32'h0, 1'b1, 1'b0, 2);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
